// File: rtl/spifs_xip_seq.sv
// Execute-in-place read sequencer: turns a bus read into the SPI master register
// sequence (optional divider setup, TXD0/TXD1/CTL writes, wait for irq, RXD0 read).
module spifs_xip_seq #(
   parameter logic [7:0]  DIV_VAL     = 8'h01,
   parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        reg_wr_o,
   output logic        reg_rd_o,
   output logic [4:0]  reg_addr_o,
   output logic [31:0] reg_wdata_o,
   input  logic [31:0] reg_rdata_i,
   input  logic        reg_ack_i,
   input  logic        irq_i,
   output logic [4:0]  state_o
);

   typedef enum logic [4:0] {
      IDLE     = 5'h0,
      SPI_CSR  = 5'h1,
      WR_TXD0  = 5'h2,
      WR_TXD1  = 5'h3,
      WR_CTL   = 5'h4,
      WAIT_IRQ = 5'h5,
      RD_RXD0  = 5'h6,
      RSP      = 5'h7
   } state_t;

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [4:0]  addr;
      logic [31:0] data;
   } reg_cmd_t;

   state_t      state, state_nxt;
   logic [22:0] addr_q;
   logic        cfg_done;
   logic [15:0] wait_cnt;
   logic        accept, in_window, cnt_last;
   reg_cmd_t    cmd_nxt;

   assign accept    = (state == IDLE) && req_valid_i && req_ready_o;
   assign in_window = (req_addr_i[31:23] == 9'h080);
   assign cnt_last  = (wait_cnt == TIMEOUT_CYC - 16'd1);
   assign state_o   = state;

   // Register-port command presented while sitting in a given state.
   function automatic reg_cmd_t cmd_for(input state_t s, input logic [22:0] a);
      cmd_for = '0;
      case (s)
         SPI_CSR: cmd_for = '{wr: 1'b1, rd: 1'b0, addr: 5'h14, data: {24'h0, DIV_VAL}};
         WR_TXD0: cmd_for = '{wr: 1'b1, rd: 1'b0, addr: 5'h00, data: 32'h0};
         WR_TXD1: cmd_for = '{wr: 1'b1, rd: 1'b0, addr: 5'h04, data: {8'h03, 1'b0, a}};
         WR_CTL:  cmd_for = '{wr: 1'b1, rd: 1'b0, addr: 5'h10, data: 32'h0100_3540};
         RD_RXD0: cmd_for = '{wr: 1'b0, rd: 1'b1, addr: 5'h00, data: 32'h0};
         default: cmd_for = '0;
      endcase
   endfunction

   assign cmd_nxt = cmd_for(state_nxt, addr_q);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = !in_window ? RSP : (cfg_done ? WR_TXD0 : SPI_CSR);
         SPI_CSR:  if (reg_ack_i) state_nxt = WR_TXD0;
         WR_TXD0:  if (reg_ack_i) state_nxt = WR_TXD1;
         WR_TXD1:  if (reg_ack_i) state_nxt = WR_CTL;
         WR_CTL:   if (reg_ack_i) state_nxt = WAIT_IRQ;
         WAIT_IRQ: begin
            if (irq_i)         state_nxt = RD_RXD0;
            else if (cnt_last) state_nxt = RSP;
         end
         RD_RXD0:  if (reg_ack_i) state_nxt = RSP;
         RSP:      if (rsp_ready_i) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_o.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         cfg_done    <= 1'b0;
         wait_cnt    <= '0;
         addr_q      <= '0;
         req_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_data_o  <= '0;
         reg_wr_o    <= 1'b0;
         reg_rd_o    <= 1'b0;
         reg_addr_o  <= '0;
         reg_wdata_o <= '0;
      end else begin
         state       <= state_nxt;
         req_ready_o <= (state_nxt == IDLE);
         rsp_valid_o <= (state_nxt == RSP);
         {reg_wr_o, reg_rd_o, reg_addr_o, reg_wdata_o} <= cmd_nxt;
         wait_cnt    <= (state == WAIT_IRQ && state_nxt == WAIT_IRQ) ? wait_cnt + 16'd1 : '0;
         if (accept) begin
            addr_q     <= req_addr_i[22:0];
            rsp_data_o <= '0;
            rsp_err_o  <= !in_window;
         end
         if (state == SPI_CSR && reg_ack_i)
            cfg_done <= 1'b1;
         if (state == WAIT_IRQ && !irq_i && cnt_last) begin
            rsp_err_o  <= 1'b1;
            rsp_data_o <= '0;
         end
         if (state == RD_RXD0 && reg_ack_i) begin
            rsp_data_o <= reg_rdata_i;
            rsp_err_o  <= 1'b0;
         end
      end
   end

endmodule
